rv_iommu_ls_arb: RTL and testbench



---
 rtl/rv_iommu_ls_arb.sv | 154 +++++++++++++++
 tb/tb_rv_iommu_ls_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iommu_ls_arb.sv
// rv_iommu_ls_arb: round-robin arbiter for the lspa load/store port, with source-tagged return routing and per-requester outstanding caps.
// Define RV_IOMMU_LS_ARB_WALKER_PRIO_EN to give requester 0 (walker) strict priority over a round-robin of the rest.
module rv_iommu_ls_arb #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_TAG_W = 3,
    parameter int MAX_OUT   = 8,
    parameter int SRC_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*46-1:0]        req_addr_i,
    input  logic [NUM_REQ*2-1:0]         req_op_i,
    input  logic [NUM_REQ*REQ_TAG_W-1:0] req_tag_i,
    input  logic [NUM_REQ*7-1:0]         req_size_i,
    input  logic [NUM_REQ-1:0]           req_irdy_i,
    output logic [NUM_REQ-1:0]           req_trdy_o,
    output logic [45:0]                  ls_addr_o,
    output logic [1:0]                   ls_op_o,
    output logic [SRC_W+REQ_TAG_W-1:0]   ls_tag_o,
    output logic [6:0]                   ls_size_o,
    output logic                         ls_req_irdy_o,
    input  logic                         ls_req_trdy_i,
    input  logic [511:0]                 ld_data_i,
    input  logic                         ld_acc_fault_i,
    input  logic                         ld_poison_i,
    input  logic [SRC_W+REQ_TAG_W-1:0]   ld_tag_i,
    input  logic                         ld_data_irdy_i,
    output logic                         ld_data_trdy_o,
    output logic [511:0]                 rsp_data_o,
    output logic                         rsp_acc_fault_o,
    output logic                         rsp_poison_o,
    output logic [REQ_TAG_W-1:0]         rsp_tag_o,
    output logic [NUM_REQ-1:0]           rsp_irdy_o,
    input  logic [NUM_REQ-1:0]           rsp_trdy_i,
    output logic                         bad_src_o
);
    localparam int NS    = 2 ** SRC_W;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [NS-1:0] SRC_OK = NS'((1 << NUM_REQ) - 1);
`ifdef RV_IOMMU_LS_ARB_WALKER_PRIO_EN
    localparam logic [SRC_W-1:0] PTR_RST = SRC_W'(1);
`else
    localparam logic [SRC_W-1:0] PTR_RST = '0;
`endif

    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] inc;
    logic [NUM_REQ-1:0] dec;
    logic               free;
    logic               found;
    logic               gnt;
    int                 gi;
    int                 idx;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   ptr_nxt;
    logic [SRC_W-1:0]   s;
    logic               src_ok;
    logic [NS-1:0]      hot;
    logic [NS-1:0]      trdy_ext;

    assign free = !ls_req_irdy_o || ls_req_trdy_i;

    // op bit 0 clear means load/AMO, the only ops that consume a return slot
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_irdy_i[i] && !(cnt[i] == CNT_W'(MAX_OUT) && !req_op_i[2*i]);
    end

`ifdef RV_IOMMU_LS_ARB_WALKER_PRIO_EN
    // ptr cycles over 1..NUM_REQ-1 only; walker grants leave it alone
    always_comb begin
        found = elig[0];
        gi    = 0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            idx = 1 + (int'(ptr) - 1 + k) % (NUM_REQ - 1);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gi    = idx;
            end
        end
        ptr_nxt = (gi == 0) ? ptr : (gi == NUM_REQ - 1) ? SRC_W'(1) : SRC_W'(gi + 1);
    end
`else
    always_comb begin
        found = 1'b0;
        gi    = 0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gi    = idx;
            end
        end
        ptr_nxt = (gi == NUM_REQ - 1) ? '0 : SRC_W'(gi + 1);
    end
`endif

    assign gnt        = free && found;
    assign req_trdy_o = gnt ? NUM_REQ'(1) << gi : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ls_req_irdy_o <= 1'b0;
            ptr           <= PTR_RST;
        end else if (free) begin
            ls_req_irdy_o <= found;
            if (found) ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt) begin
            ls_addr_o <= req_addr_i[gi*46 +: 46];
            ls_op_o   <= req_op_i[gi*2 +: 2];
            ls_tag_o  <= {SRC_W'(gi), req_tag_i[gi*REQ_TAG_W +: REQ_TAG_W]};
            ls_size_o <= req_size_i[gi*7 +: 7];
        end
    end

    always_comb begin
        inc = '0;
        dec = rsp_irdy_o & rsp_trdy_i;
        if (gnt && !req_op_i[2*gi]) inc[gi] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) cnt[i] <= '0;
            else if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 1'b1;
            else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
    end

    // returns with a source index beyond NUM_REQ are swallowed and flagged
    assign s               = ld_tag_i[SRC_W+REQ_TAG_W-1 -: SRC_W];
    assign src_ok          = SRC_OK[s];
    assign hot             = NS'(ld_data_irdy_i) << s;
    assign trdy_ext        = NS'(rsp_trdy_i);
    assign rsp_irdy_o      = src_ok ? hot[NUM_REQ-1:0] : '0;
    assign ld_data_trdy_o  = src_ok ? trdy_ext[s] : 1'b1;
    assign rsp_data_o      = ld_data_i;
    assign rsp_acc_fault_o = ld_acc_fault_i;
    assign rsp_poison_o    = ld_poison_i;
    assign rsp_tag_o       = ld_tag_i[REQ_TAG_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) bad_src_o <= 1'b0;
        else if (ld_data_irdy_i && !src_ok) bad_src_o <= 1'b1;
    end
endmodule

// File: tb/tb_rv_iommu_ls_arb.sv
// tb_rv_iommu_ls_arb: scoreboard bench for rv_iommu_ls_arb, default build plus a NUM_REQ=3 instance for illegal return sources.
module tb_rv_iommu_ls_arb;
    typedef struct packed {
        logic [45:0] addr;
        logic [1:0]  op;
        logic [4:0]  tag;
        logic [6:0]  size;
    } ls_t;
    typedef struct packed {
        logic [3:0]  hot;
        logic [2:0]  tag;
        logic [31:0] data;
        logic        poison;
        logic        fault;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [183:0] req_addr_i;
    logic [7:0]   req_op_i;
    logic [11:0]  req_tag_i;
    logic [27:0]  req_size_i;
    logic [3:0]   req_irdy_i, req_trdy_o;
    logic [45:0]  ls_addr_o;
    logic [1:0]   ls_op_o;
    logic [4:0]   ls_tag_o;
    logic [6:0]   ls_size_o;
    logic         ls_req_irdy_o, ls_req_trdy_i;
    logic [511:0] ld_data_i, rsp_data_o;
    logic         ld_acc_fault_i, ld_poison_i;
    logic [4:0]   ld_tag_i;
    logic         ld_data_irdy_i, ld_data_trdy_o, rsp_acc_fault_o, rsp_poison_o;
    logic [2:0]   rsp_tag_o;
    logic [3:0]   rsp_irdy_o, rsp_trdy_i;
    logic         bad_src_o;

    logic [137:0] d3_req_addr = '0;
    logic [5:0]   d3_req_op = '0;
    logic [8:0]   d3_req_tag = '0;
    logic [20:0]  d3_req_size = '0;
    logic [2:0]   d3_req_irdy = '0, d3_req_trdy;
    logic [45:0]  d3_ls_addr;
    logic [1:0]   d3_ls_op;
    logic [4:0]   d3_ls_tag;
    logic [6:0]   d3_ls_size;
    logic         d3_ls_irdy;
    logic [511:0] d3_rsp_data;
    logic         d3_rsp_fault, d3_rsp_poison;
    logic [2:0]   d3_rsp_tag;
    logic [4:0]   d3_ld_tag;
    logic         d3_ld_irdy, d3_ld_trdy;
    logic [2:0]   d3_rsp_irdy, d3_rsp_trdy;
    logic         d3_bad_src;

    rv_iommu_ls_arb u_dut (
        .clk(clk), .rst(rst),
        .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_tag_i(req_tag_i), .req_size_i(req_size_i),
        .req_irdy_i(req_irdy_i), .req_trdy_o(req_trdy_o),
        .ls_addr_o(ls_addr_o), .ls_op_o(ls_op_o), .ls_tag_o(ls_tag_o), .ls_size_o(ls_size_o),
        .ls_req_irdy_o(ls_req_irdy_o), .ls_req_trdy_i(ls_req_trdy_i),
        .ld_data_i(ld_data_i), .ld_acc_fault_i(ld_acc_fault_i), .ld_poison_i(ld_poison_i),
        .ld_tag_i(ld_tag_i), .ld_data_irdy_i(ld_data_irdy_i), .ld_data_trdy_o(ld_data_trdy_o),
        .rsp_data_o(rsp_data_o), .rsp_acc_fault_o(rsp_acc_fault_o), .rsp_poison_o(rsp_poison_o),
        .rsp_tag_o(rsp_tag_o), .rsp_irdy_o(rsp_irdy_o), .rsp_trdy_i(rsp_trdy_i), .bad_src_o(bad_src_o)
    );

    rv_iommu_ls_arb #(.NUM_REQ(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_addr_i(d3_req_addr), .req_op_i(d3_req_op), .req_tag_i(d3_req_tag), .req_size_i(d3_req_size),
        .req_irdy_i(d3_req_irdy), .req_trdy_o(d3_req_trdy),
        .ls_addr_o(d3_ls_addr), .ls_op_o(d3_ls_op), .ls_tag_o(d3_ls_tag), .ls_size_o(d3_ls_size),
        .ls_req_irdy_o(d3_ls_irdy), .ls_req_trdy_i(1'b1),
        .ld_data_i(512'd0), .ld_acc_fault_i(1'b0), .ld_poison_i(1'b0),
        .ld_tag_i(d3_ld_tag), .ld_data_irdy_i(d3_ld_irdy), .ld_data_trdy_o(d3_ld_trdy),
        .rsp_data_o(d3_rsp_data), .rsp_acc_fault_o(d3_rsp_fault), .rsp_poison_o(d3_rsp_poison),
        .rsp_tag_o(d3_rsp_tag), .rsp_irdy_o(d3_rsp_irdy), .rsp_trdy_i(d3_rsp_trdy), .bad_src_o(d3_bad_src)
    );

    logic [45:0] a_tab [4];
    logic [1:0]  o_tab [4];
    logic [2:0]  t_tab [4];
    logic [6:0]  s_tab [4];
    ls_t  ls_q [$];
    ret_t ret_q [$];
    ls_t  e_ls;
    ret_t e_ret;
    int   n_chk = 0;
    int   n_fail = 0;
    int   g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [45:0] a, input logic [1:0] o,
                           input logic [2:0] t, input logic [6:0] sz);
        a_tab[i] = a; o_tab[i] = o; t_tab[i] = t; s_tab[i] = sz;
        req_addr_i[i*46 +: 46] = a;
        req_op_i[i*2 +: 2]     = o;
        req_tag_i[i*3 +: 3]    = t;
        req_size_i[i*7 +: 7]   = sz;
    endtask

    function automatic ls_t exp_of(input int i);
        return {a_tab[i], o_tab[i], 2'(i), t_tab[i], s_tab[i]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ls_req_irdy_o && ls_req_trdy_i) begin
            if (ls_q.size() == 0) chk("ls_unexpected", 64'(ls_req_irdy_o), 64'd0);
            else begin
                e_ls = ls_q.pop_front();
                chk("ls_req", 64'({ls_addr_o, ls_op_o, ls_tag_o, ls_size_o}), 64'(e_ls));
            end
        end
        if (!rst && ld_data_irdy_i && ld_data_trdy_o && rsp_irdy_o != 4'd0) begin
            if (ret_q.size() == 0) chk("ret_unexpected", 64'(rsp_irdy_o), 64'd0);
            else begin
                e_ret = ret_q.pop_front();
                chk("ret", 64'({rsp_irdy_o, rsp_tag_o, rsp_data_o[31:0], rsp_poison_o, rsp_acc_fault_o}), 64'(e_ret));
            end
        end
    end

    initial begin
        req_addr_i = '0; req_op_i = '0; req_tag_i = '0; req_size_i = '0; req_irdy_i = '0;
        ls_req_trdy_i = 1'b1; ld_data_i = '0; ld_acc_fault_i = 1'b0; ld_poison_i = 1'b0;
        ld_tag_i = '0; ld_data_irdy_i = 1'b0; rsp_trdy_i = '0;
        d3_ld_tag = '0; d3_ld_irdy = 1'b0; d3_rsp_trdy = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ls_irdy", 64'(ls_req_irdy_o), 64'd0);
        chk("rst_bad_src", 64'(bad_src_o), 64'd0);
        chk("rst_bad_src3", 64'(d3_bad_src), 64'd0);
        chk("rst_trdy", 64'(req_trdy_o), 64'd0);
        tick;
        rst = 1'b0;

        // single walker load
        set_req(0, 46'h123456, 2'b00, 3'd5, 7'd8);
        req_irdy_i = 4'b0001;
        ls_q.push_back(exp_of(0));
        @(negedge clk); chk("walker_gnt", 64'(req_trdy_o), 64'b0001);
        tick;
        req_irdy_i = '0;
        @(negedge clk); tick;

        // fresh round robin with all four valid (stores, so counts stay clear)
        rst = 1'b1; tick; rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 46'h1000 * (i + 1), 2'b01, 3'(i + 1), 7'(i + 4));
        req_irdy_i = 4'hf;
        for (int k = 0; k < 8; k++) begin
`ifdef RV_IOMMU_LS_ARB_WALKER_PRIO_EN
            g = 0;
`else
            g = k % 4;
`endif
            ls_q.push_back(exp_of(g));
            @(negedge clk); chk("rr_gnt", 64'(req_trdy_o), 64'(4'b0001 << g));
            tick;
        end
        req_irdy_i = '0;
        @(negedge clk); tick;

        // backpressure: walker store held for 3 cycles while FQ waits
        ls_req_trdy_i = 1'b0;
        set_req(0, 46'h2AAAA, 2'b01, 3'd6, 7'd16);
        req_irdy_i = 4'b0001;
        ls_q.push_back(exp_of(0));
        @(negedge clk); chk("bp_first_gnt", 64'(req_trdy_o), 64'b0001);
        tick;
        set_req(2, 46'h3BBBB, 2'b00, 3'd7, 7'd64);
        req_irdy_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_trdy", 64'(req_trdy_o), 64'd0);
            chk("bp_addr", 64'(ls_addr_o), 64'h2AAAA);
            chk("bp_irdy", 64'(ls_req_irdy_o), 64'd1);
            tick;
        end
        ls_req_trdy_i = 1'b1;
        ls_q.push_back(exp_of(2));
        @(negedge clk); chk("bp_fq_gnt", 64'(req_trdy_o), 64'b0100);
        tick;
        req_irdy_i = '0;
        @(negedge clk); tick;

        // CQ outstanding cap
        req_irdy_i = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            set_req(1, 46'h4000 + 46'(k), 2'b00, 3'(k), 7'd4);
            ls_q.push_back(exp_of(1));
            @(negedge clk); chk("cap_load", 64'(req_trdy_o), 64'b0010);
            tick;
        end
        set_req(1, 46'h4100, 2'b00, 3'd0, 7'd4);
        @(negedge clk); chk("cap_block", 64'(req_trdy_o), 64'd0);
        tick;
        set_req(1, 46'h4200, 2'b01, 3'd1, 7'd4);
        ls_q.push_back(exp_of(1));
        @(negedge clk); chk("cap_store", 64'(req_trdy_o), 64'b0010);
        tick;
        set_req(1, 46'h4100, 2'b00, 3'd0, 7'd4);
        ld_tag_i = {2'd1, 3'd3}; ld_data_i = {480'd0, 32'hCAFE0001}; ld_poison_i = 1'b1;
        ld_data_irdy_i = 1'b1; rsp_trdy_i = 4'b0010;
        ret_q.push_back({4'b0010, 3'd3, 32'hCAFE0001, 1'b1, 1'b0});
        @(negedge clk);
        chk("cap_same_cycle", 64'(req_trdy_o), 64'd0);
        chk("cq_rsp_irdy", 64'(rsp_irdy_o), 64'b0010);
        tick;
        ld_data_irdy_i = 1'b0; rsp_trdy_i = '0; ld_poison_i = 1'b0;
        ls_q.push_back(exp_of(1));
        @(negedge clk); chk("cap_unblock", 64'(req_trdy_o), 64'b0010);
        tick;
        req_irdy_i = '0;
        @(negedge clk); tick;

        // return to PQ with ready low then high
        ld_tag_i = {2'd3, 3'd2}; ld_data_i = {480'd0, 32'h5555AAAA}; ld_acc_fault_i = 1'b1;
        ld_data_irdy_i = 1'b1; rsp_trdy_i = 4'b0000;
        @(negedge clk);
        chk("pq_rsp_irdy", 64'(rsp_irdy_o), 64'b1000);
        chk("pq_trdy_low", 64'(ld_data_trdy_o), 64'd0);
        chk("pq_rsp_tag", 64'(rsp_tag_o), 64'd2);
        tick;
        rsp_trdy_i = 4'b1000;
        ret_q.push_back({4'b1000, 3'd2, 32'h5555AAAA, 1'b0, 1'b1});
        @(negedge clk); chk("pq_trdy_high", 64'(ld_data_trdy_o), 64'd1);
        tick;
        ld_data_irdy_i = 1'b0; rsp_trdy_i = '0; ld_acc_fault_i = 1'b0;
        @(negedge clk); chk("main_bad_src", 64'(bad_src_o), 64'd0);
        tick;

        // NUM_REQ=3: illegal source 3 is dropped and flagged
        d3_ld_tag = {2'd3, 3'd1}; d3_ld_irdy = 1'b1; d3_rsp_trdy = '0;
        @(negedge clk);
        chk("d3_drop_trdy", 64'(d3_ld_trdy), 64'd1);
        chk("d3_drop_irdy", 64'(d3_rsp_irdy), 64'd0);
        tick;
        d3_ld_irdy = 1'b0;
        @(negedge clk); chk("d3_bad_set", 64'(d3_bad_src), 64'd1);
        tick;
        d3_ld_tag = {2'd2, 3'd0}; d3_ld_irdy = 1'b1; d3_rsp_trdy = 3'b100;
        @(negedge clk);
        chk("d3_legal_irdy", 64'(d3_rsp_irdy), 64'b100);
        chk("d3_legal_trdy", 64'(d3_ld_trdy), 64'd1);
        chk("d3_bad_sticky", 64'(d3_bad_src), 64'd1);
        tick;
        d3_ld_irdy = 1'b0; d3_rsp_trdy = '0;
        chk("ls_q_empty", 64'(ls_q.size()), 64'd0);
        chk("ret_q_empty", 64'(ret_q.size()), 64'd0);
        rst = 1'b1; tick; rst = 1'b0;
        @(negedge clk); chk("d3_bad_clear", 64'(d3_bad_src), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
